// File: rtl/clk_div_prog.sv
// Runtime-programmable divide-by-N clock generator with 50% duty for odd and even N.
// New divisors are staged in a shadow register and applied only at a period boundary.
module clk_div_prog #(
    parameter int CNT_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_load,
    output logic [CNT_W-1:0] div_cur,
    output logic             div_pending,
    output logic             div_err,
    output logic             tick,
    output logic             clk_out
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

    logic [CNT_W-1:0] div_cur_q, div_cur_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             err_q, err_d;
    logic             run_q, run_d;
    logic             pos_hi_q, pos_hi_d;
    logic             tick_q, tick_d;
    logic             neg_hi_q;

    logic [CNT_W-1:0] half;
    logic [CNT_W-1:0] cnt_inc;
    logic             at_end;
    logic             load_ok;

    always_comb begin
        half     = div_cur_q >> 1;
        cnt_inc  = cnt_q + ONE;
        at_end   = (cnt_q == div_cur_q - ONE);
        load_ok  = div_load && (div_in >= TWO);

        div_cur_d = div_cur_q;
        shadow_d  = shadow_q;
        pend_d    = pend_q;
        cnt_d     = cnt_q;
        run_d     = run_q;
        pos_hi_d  = pos_hi_q;

        if (!enable) begin
            run_d    = 1'b0;
            cnt_d    = '0;
            pos_hi_d = 1'b0;
        end else if (!run_q) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            pos_hi_d = 1'b1;
        end else if (at_end) begin
            cnt_d    = '0;
            pos_hi_d = 1'b1;
            if (pend_q) begin
                div_cur_d = shadow_q;
                pend_d    = 1'b0;
            end
        end else begin
            cnt_d    = cnt_inc;
            pos_hi_d = (cnt_inc < half);
        end

        // A load coinciding with a wrap stays pending for the following boundary.
        if (load_ok) begin
            shadow_d = div_in;
            pend_d   = 1'b1;
        end

        err_d  = div_load && !load_ok;
        tick_d = run_d && (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cur_q <= DIV_RST;
            shadow_q  <= '0;
            pend_q    <= 1'b0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            pos_hi_q  <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            div_cur_q <= div_cur_d;
            shadow_q  <= shadow_d;
            pend_q    <= pend_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            pos_hi_q  <= pos_hi_d;
            tick_q    <= tick_d;
        end
    end

    // Half-cycle delayed copy; stretches the high phase for odd divisors.
    always_ff @(negedge clk) begin
        if (reset) begin
            neg_hi_q <= 1'b0;
        end else begin
            neg_hi_q <= pos_hi_q;
        end
    end

    assign clk_out     = pos_hi_q | (div_cur_q[0] & neg_hi_q);
    assign div_cur     = div_cur_q;
    assign div_pending = pend_q;
    assign div_err     = err_q;
    assign tick        = tick_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: stimulus queues expected period length and
// high time (in half cycles); a monitor measures each period between ticks and compares.
module tb_clk_div_prog;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic             div_load;
    logic [CNT_W-1:0] div_in;
    logic [CNT_W-1:0] div_cur;
    logic             div_pending;
    logic             div_err;
    logic             tick;
    logic             clk_out;

    typedef struct {
        int len;
        int hi;
    } period_t;

    period_t exp_q[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    bit      meas_en = 1'b0;
    bit      have_prev = 1'b0;
    int      cyc = 0;
    int      hi = 0;

    clk_div_prog #(.CNT_W(CNT_W), .DEFAULT_DIV(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .div_in      (div_in),
        .div_load    (div_load),
        .div_cur     (div_cur),
        .div_pending (div_pending),
        .div_err     (div_err),
        .tick        (tick),
        .clk_out     (clk_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // An even or odd N period is N half-cycles high out of 2N.
    task automatic expect_periods(input int n, input int len);
        period_t e;
        e.len = len;
        e.hi  = len;
        for (int i = 0; i < n; i++) exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_tick(input string name);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!tick && k < 600);
        chk(name, tick, 1);
    endtask

    // Monitor: posedge sample closes a period on tick, both edges count high halves.
    initial begin
        period_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!meas_en) begin
                have_prev = 1'b0;
            end else if (tick) begin
                if (have_prev) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_period", cyc, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("period_len", cyc, e.len);
                        chk("high_halves", hi, e.hi);
                    end
                end
                have_prev = 1'b1;
                cyc = 0;
                hi  = 0;
            end
            cyc++;
            if (clk_out) hi++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (clk_out) hi++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        div_load = 1'b0;
        div_in   = '0;
        repeat (3) step();
        chk("rst_div_cur", div_cur, 3);
        chk("rst_pending", div_pending, 0);
        chk("rst_err", div_err, 0);
        chk("rst_tick", tick, 0);
        chk("rst_clk_out", clk_out, 0);

        // Default N=3
        reset   = 1'b0;
        enable  = 1'b1;
        meas_en = 1'b1;
        expect_periods(3, 3);
        wait_tick("start_tick");
        chk("start_clk_out", clk_out, 1);
        repeat (3) wait_tick("n3_tick");

        // Load N=4 mid-period
        expect_periods(1, 3);
        expect_periods(3, 4);
        step();
        div_in   = 8'd4;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        chk("n4_pending", div_pending, 1);
        chk("n4_cur_before", div_cur, 3);
        wait_tick("n4_wrap");
        chk("n4_cur_after", div_cur, 4);
        chk("n4_pending_after", div_pending, 0);
        repeat (3) wait_tick("n4_tick");

        // Load 7 then 10 before the boundary: last one wins
        expect_periods(1, 4);
        expect_periods(2, 10);
        step();
        div_in   = 8'd7;
        div_load = 1'b1;
        step();
        div_in   = 8'd10;
        step();
        div_load = 1'b0;
        chk("n10_pending", div_pending, 1);
        chk("n10_cur_before", div_cur, 4);
        wait_tick("n10_wrap");
        chk("n10_cur_after", div_cur, 10);
        repeat (2) wait_tick("n10_tick");

        // Rejected divisors 1 and 0
        expect_periods(2, 10);
        step();
        div_in   = 8'd1;
        div_load = 1'b1;
        step();
        div_in   = 8'd0;
        chk("err_div1", div_err, 1);
        chk("err_div1_pending", div_pending, 0);
        step();
        div_load = 1'b0;
        chk("err_div0", div_err, 1);
        step();
        chk("err_clear", div_err, 0);
        chk("err_cur", div_cur, 10);
        chk("err_pending", div_pending, 0);
        repeat (2) wait_tick("err_tick");

        // Disable for 5 cycles during the high phase
        meas_en = 1'b0;
        step();
        chk("pre_dis_clk_out", clk_out, 1);
        enable = 1'b0;
        step();
        chk("dis_clk_out", clk_out, 0);
        chk("dis_tick", tick, 0);
        repeat (4) step();
        chk("dis_hold_clk_out", clk_out, 0);
        chk("dis_cur", div_cur, 10);
        enable  = 1'b1;
        meas_en = 1'b1;
        expect_periods(2, 10);
        step();
        chk("reen_tick", tick, 1);
        chk("reen_clk_out", clk_out, 1);
        repeat (2) wait_tick("reen_period_tick");

        // Reset mid-period with a divisor pending
        meas_en = 1'b0;
        step();
        div_in   = 8'd5;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        chk("rst6_pending_before", div_pending, 1);
        reset = 1'b1;
        step();
        chk("rst6_cur", div_cur, 3);
        chk("rst6_pending", div_pending, 0);
        chk("rst6_tick", tick, 0);
        chk("rst6_err", div_err, 0);
        @(negedge clk);
        #2;
        chk("rst6_clk_out", clk_out, 0);

        // N=255
        step();
        reset    = 1'b0;
        div_in   = 8'd255;
        div_load = 1'b1;
        step();
        div_load = 1'b0;
        meas_en  = 1'b1;
        chk("n255_pending", div_pending, 1);
        chk("n255_cur_before", div_cur, 3);
        expect_periods(2, 255);
        wait_tick("n255_wrap");
        chk("n255_cur", div_cur, 255);
        chk("n255_pending_after", div_pending, 0);
        repeat (2) wait_tick("n255_tick");

        repeat (2) step();
        chk("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
